// File: rtl/lsu_mem_master.sv
// Load/store initiator between the EX/MEM boundary and the data memory port.
// Aligned accesses are issued as a single memory cycle. Misaligned half/word
// accesses are either split into byte cycles or rejected with an error,
// depending on ALLOW_MISALIGNED.
//
// Request handshake: a request transfers on a rising clock edge where
// req_valid and req_ready are both high. req_ready is high only in IDLE, so a
// request presented while the block is busy simply waits. The response is a
// single-cycle resp_valid pulse with no backpressure; resp_rdata/resp_err are
// zero whenever resp_valid is low.
module lsu_mem_master #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_W_en,
    output logic        mem_R_en,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_RW_type,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_SPLIT  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_store;
    logic [2:0]  r_type;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_k;
    logic [1:0]  r_last;
    logic [31:0] r_asm;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_mem_W_en;
    logic        r_mem_R_en;
    logic [31:0] r_mem_addr;
    logic [2:0]  r_mem_RW_type;
    logic [31:0] r_mem_din;

    logic        w_illegal;
    logic        w_misaligned;
    logic [1:0]  w_k_inc;
    logic [7:0]  w_split_wbyte;
    logic [31:0] w_asm_next;

    // Sign- or zero-extend the low byte/half of d according to the access type.
    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] t);
        logic [31:0] res;
        case (t[1:0])
            2'b00:   res = t[2] ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   res = t[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: res = d;
        endcase
        return res;
    endfunction

    assign w_illegal     = (req_type == 3'b011) || (req_type == 3'b110) || (req_type == 3'b111);
    assign w_misaligned  = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_type[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_k_inc       = r_k + 2'd1;
    assign w_split_wbyte = r_wdata[{w_k_inc, 3'b000} +: 8];

    // Load assembly buffer with the byte returned in the current split cycle merged in.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_k, 3'b000} +: 8] = mem_dout[7:0];
    end

    // Main FSM: state, captured request, memory port and response, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_store       <= 1'b0;
            r_type        <= 3'b000;
            r_addr        <= 32'b0;
            r_wdata       <= 32'b0;
            r_k           <= 2'd0;
            r_last        <= 2'd0;
            r_asm         <= 32'b0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= 32'b0;
            r_resp_err    <= 1'b0;
            r_mem_W_en    <= 1'b0;
            r_mem_R_en    <= 1'b0;
            r_mem_addr    <= 32'b0;
            r_mem_RW_type <= 3'b000;
            r_mem_din     <= 32'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store     <= req_store;
                        r_type      <= req_type;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_illegal || (w_misaligned && !ALLOW_MISALIGNED)) begin
                            // Rejected without touching memory.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'b0;
                        end else if (w_misaligned) begin
                            // First byte of the split goes out on the next cycle.
                            r_state       <= S_SPLIT;
                            r_k           <= 2'd0;
                            r_last        <= (req_type[1:0] == 2'b01) ? 2'd1 : 2'd3;
                            r_asm         <= 32'b0;
                            r_mem_W_en    <= req_store;
                            r_mem_R_en    <= !req_store;
                            r_mem_addr    <= req_addr;
                            r_mem_RW_type <= 3'b100;
                            r_mem_din     <= req_store ? {24'b0, req_wdata[7:0]} : 32'b0;
                        end else begin
                            r_state       <= S_ACCESS;
                            r_mem_W_en    <= req_store;
                            r_mem_R_en    <= !req_store;
                            r_mem_addr    <= req_addr;
                            r_mem_RW_type <= req_type;
                            r_mem_din     <= req_store ? req_wdata : 32'b0;
                        end
                    end
                end

                S_ACCESS: begin
                    r_state       <= S_RESP;
                    r_mem_W_en    <= 1'b0;
                    r_mem_R_en    <= 1'b0;
                    r_mem_addr    <= 32'b0;
                    r_mem_RW_type <= 3'b000;
                    r_mem_din     <= 32'b0;
                    r_resp_valid  <= 1'b1;
                    r_resp_err    <= mem_error;
                    r_resp_rdata  <= (!r_store && !mem_error) ? extend(mem_dout, r_type) : 32'b0;
                end

                S_SPLIT: begin
                    if (mem_error || (r_k == r_last)) begin
                        // Abort on error (already-written bytes stay written) or finish.
                        r_state       <= S_RESP;
                        r_mem_W_en    <= 1'b0;
                        r_mem_R_en    <= 1'b0;
                        r_mem_addr    <= 32'b0;
                        r_mem_RW_type <= 3'b000;
                        r_mem_din     <= 32'b0;
                        r_resp_valid  <= 1'b1;
                        r_resp_err    <= mem_error;
                        r_resp_rdata  <= (!r_store && !mem_error) ? extend(w_asm_next, r_type) : 32'b0;
                    end else begin
                        r_asm      <= w_asm_next;
                        r_k        <= w_k_inc;
                        r_mem_addr <= r_addr + {30'b0, w_k_inc};
                        r_mem_din  <= r_store ? {24'b0, w_split_wbyte} : 32'b0;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign mem_W_en    = r_mem_W_en;
    assign mem_R_en    = r_mem_R_en;
    assign mem_addr    = r_mem_addr;
    assign mem_RW_type = r_mem_RW_type;
    assign mem_din     = r_mem_din;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: a byte-array memory model with combinational read
// and an injectable error address, plus a second instance built with
// misaligned accesses disabled.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_type = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_W_en;
  logic        mem_R_en;
  logic [31:0] mem_addr;
  logic [2:0]  mem_RW_type;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_error;
  logic [1:0]  dbg_state;

  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic        req0_store = 1'b0;
  logic [2:0]  req0_type = 3'b000;
  logic [31:0] req0_addr = 32'b0;
  logic [31:0] req0_wdata = 32'b0;
  logic        resp0_valid;
  logic [31:0] resp0_rdata;
  logic        resp0_err;
  logic        mem0_W_en;
  logic        mem0_R_en;
  logic [31:0] mem0_addr;
  logic [2:0]  mem0_RW_type;
  logic [31:0] mem0_din;
  logic [31:0] mem0_dout = 32'b0;
  logic        mem0_error = 1'b0;
  logic [1:0]  dbg0_state;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:2047];
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'b0;
  logic [10:0] ma;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int en0_cnt = 0;

  lsu_mem_master #(.ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
    .mem_RW_type(mem_RW_type), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_error(mem_error), .dbg_state(dbg_state)
  );

  lsu_mem_master #(.ALLOW_MISALIGNED(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req0_valid), .req_ready(req0_ready), .req_store(req0_store),
    .req_type(req0_type), .req_addr(req0_addr), .req_wdata(req0_wdata),
    .resp_valid(resp0_valid), .resp_rdata(resp0_rdata), .resp_err(resp0_err),
    .mem_W_en(mem0_W_en), .mem_R_en(mem0_R_en), .mem_addr(mem0_addr),
    .mem_RW_type(mem0_RW_type), .mem_din(mem0_din), .mem_dout(mem0_dout),
    .mem_error(mem0_error), .dbg_state(dbg0_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  assign ma = mem_addr[10:0];
  assign mem_error = err_en && (mem_R_en || mem_W_en) && (mem_addr == err_addr);

  always_comb begin
    case (mem_RW_type[1:0])
      2'b00:   mem_dout = {24'b0, mem[ma]};
      2'b01:   mem_dout = {16'b0, mem[ma + 11'd1], mem[ma]};
      default: mem_dout = {mem[ma + 11'd3], mem[ma + 11'd2], mem[ma + 11'd1], mem[ma]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_W_en && !mem_error) begin
      mem[ma] = mem_din[7:0];
      if (mem_RW_type[1:0] != 2'b00) mem[ma + 11'd1] = mem_din[15:8];
      if (mem_RW_type[1] == 1'b1) begin
        mem[ma + 11'd2] = mem_din[23:16];
        mem[ma + 11'd3] = mem_din[31:24];
      end
    end
  end

  always @(negedge clk) begin
    if (mem_R_en) rd_cnt++;
    if (mem_W_en) wr_cnt++;
    if (mem_R_en && mem_W_en) both_cnt++;
    if (mem0_R_en || mem0_W_en) en0_cnt++;
  end

  // ---------------- driver ----------------
  // Called at #1 after an edge with the DUT idle; returns at the same phase, idle again.
  task automatic do_req(input logic st, input logic [2:0] ty, input logic [31:0] ad,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er);
    req_store = st; req_type = ty; req_addr = ad; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    n_checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'b0) begin
      n_fail++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0", resp_valid, resp_err, resp_rdata);
    end
    n_checks++;
    if ({mem_W_en, mem_R_en, mem_addr, mem_RW_type, mem_din} !== 69'b0) begin
      n_fail++; $display("FAIL reset_mem got w=%b r=%b a=%h t=%b d=%h exp 0", mem_W_en, mem_R_en, mem_addr, mem_RW_type, mem_din);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_aligned();
    int lat; logic [31:0] rd; logic er; int r0, w0;
    w0 = wr_cnt;
    do_req(1'b1, 3'b010, 32'h10, 32'h8899AABB, lat, rd, er);
    n_checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0 || wr_cnt - w0 != 1) begin
      n_fail++; $display("FAIL aligned_sw got lat=%0d err=%b rd=%h wr=%0d exp lat=2 err=0 rd=0 wr=1", lat, er, rd, wr_cnt - w0);
    end
    r0 = rd_cnt;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL aligned_lw_lat got %0d exp 2", lat); end
    n_checks++;
    if (rd !== 32'h8899AABB || er !== 1'b0) begin
      n_fail++; $display("FAIL aligned_lw_data got %h err=%b exp 8899aabb err=0", rd, er);
    end
    n_checks++;
    if (rd_cnt - r0 != 1) begin n_fail++; $display("FAIL aligned_lw_reads got %0d exp 1", rd_cnt - r0); end
  endtask

  task automatic test_byte_half();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 3'b010, 32'h10, 32'h000080FF, lat, rd, er);
    do_req(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFFF80 || lat != 2) begin n_fail++; $display("FAIL lb got %h lat=%0d exp ffffff80 lat=2", rd, lat); end
    do_req(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h exp 00000080", rd); end
    do_req(1'b1, 3'b001, 32'h12, 32'h0000DEAD, lat, rd, er);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'hDEAD80FF) begin n_fail++; $display("FAIL sh_then_lw got %h exp dead80ff", rd); end
  endtask

  task automatic test_split();
    int lat; logic [31:0] rd; logic er; int r0, w0;
    w0 = wr_cnt;
    do_req(1'b1, 3'b010, 32'h0D, 32'h11223344, lat, rd, er);
    n_checks++;
    if (lat != 5 || er !== 1'b0 || wr_cnt - w0 != 4) begin
      n_fail++; $display("FAIL split_sw got lat=%0d err=%b wr=%0d exp lat=5 err=0 wr=4", lat, er, wr_cnt - w0);
    end
    n_checks++;
    if ({mem[13], mem[14], mem[15], mem[16]} !== 32'h44332211) begin
      n_fail++; $display("FAIL split_sw_bytes got %h exp 44332211", {mem[13], mem[14], mem[15], mem[16]});
    end
    r0 = rd_cnt;
    do_req(1'b0, 3'b010, 32'h0D, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h11223344 || lat != 5 || rd_cnt - r0 != 4) begin
      n_fail++; $display("FAIL split_lw got %h lat=%0d rd=%0d exp 11223344 lat=5 rd=4", rd, lat, rd_cnt - r0);
    end
    do_req(1'b0, 3'b001, 32'h11, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFAD80 || lat != 3) begin n_fail++; $display("FAIL split_lh got %h lat=%0d exp ffffad80 lat=3", rd, lat); end
    do_req(1'b0, 3'b101, 32'h11, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h0000AD80) begin n_fail++; $display("FAIL split_lhu got %h exp 0000ad80", rd); end
  endtask

  task automatic test_split_error();
    int lat; logic [31:0] rd; logic er;
    err_en = 1'b1; err_addr = 32'h400;
    do_req(1'b0, 3'b010, 32'h3FE, 32'h0, lat, rd, er);
    err_en = 1'b0;
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 4) begin
      n_fail++; $display("FAIL split_err got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=4", er, rd, lat);
    end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] rd; logic er; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b0, 3'b111, 32'h10, 32'h0, lat, rd, er);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || rd_cnt != r0) begin
      n_fail++; $display("FAIL illegal_ld got err=%b rd=%h lat=%0d reads=%0d exp err=1 rd=0 lat=1 reads=0", er, rd, lat, rd_cnt - r0);
    end
    do_req(1'b1, 3'b011, 32'h10, 32'h12345678, lat, rd, er);
    n_checks++;
    if (er !== 1'b1 || wr_cnt != w0 || mem[16] !== 8'h11) begin
      n_fail++; $display("FAIL illegal_st got err=%b writes=%0d byte=%h exp err=1 writes=0 byte=11", er, wr_cnt - w0, mem[16]);
    end
  endtask

  task automatic test_reject_misaligned();
    int e0;
    e0 = en0_cnt;
    req0_store = 1'b0; req0_type = 3'b001; req0_addr = 32'h01; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_checks++;
    if (resp0_valid !== 1'b1 || resp0_err !== 1'b1 || resp0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reject_resp got v=%b e=%b d=%h exp v=1 e=1 d=0", resp0_valid, resp0_err, resp0_rdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if (resp0_valid !== 1'b0 || req0_ready !== 1'b1 || en0_cnt != e0) begin
      n_fail++; $display("FAIL reject_after got v=%b rdy=%b en=%0d exp v=0 rdy=1 en=0", resp0_valid, req0_ready, en0_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int pulses; int r0; logic rdy_after_accept;
    pulses = 0; r0 = rd_cnt;
    req_store = 1'b0; req_type = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    rdy_after_accept = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) rdy_after_accept = req_ready;
      if (resp_valid) pulses++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (pulses != 2 || rd_cnt - r0 != 2) begin
      n_fail++; $display("FAIL b2b got pulses=%0d reads=%0d exp pulses=2 reads=2", pulses, rd_cnt - r0);
    end
    n_checks++;
    if (rdy_after_accept !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready got %b exp 0", rdy_after_accept); end
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL rw_exclusive got %0d exp 0", both_cnt); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    req_store = 1'b1; req_type = 3'b010; req_addr = 32'h21; req_wdata = 32'hA1B2C3D4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_W_en, mem_R_en, mem_addr, mem_RW_type, mem_din} !== 103'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_outputs got v=%b w=%b a=%h d=%h rdy=%b exp all 0 rdy=1", resp_valid, mem_W_en, mem_addr, mem_din, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_after got pulses=%0d rdy=%b exp 0 1", pulses, req_ready);
    end
    n_checks++;
    if ({mem[33], mem[34], mem[35]} !== 24'hD4C300) begin
      n_fail++; $display("FAIL rst_mid_bytes got %h exp d4c300", {mem[33], mem[34], mem[35]});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_aligned();
    test_byte_half();
    test_split();
    test_split_error();
    test_illegal();
    test_reject_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
